// File: rtl/gcm_ghash_tag_pkg.sv
// gcm_pkg: shared GCM types, reduction constant and the single-bit GF(2^128) multiply step
package gcm_pkg;
  typedef logic [0:127] block_t;
  typedef enum logic [2:0] {PH_NONE = 3'd0, PH_AAD = 3'd1, PH_DATA = 3'd2, PH_LEN = 3'd3} phase_t;
  typedef enum logic [1:0] {S_IDLE, S_ACC, S_MUL, S_TAG} state_t;
  typedef struct packed {
    block_t z;
    block_t v;
  } gf_t;
  localparam block_t GF128_R = {8'he1, 120'd0};
  // Bit 0 is x^0, so a right shift multiplies V by x and V[127] is the carry out
  function automatic gf_t gf128_step(gf_t s, logic b);
    gf_t r;
    r.z = b ? s.z ^ s.v : s.z;
    r.v = s.v[127] ? (s.v >> 1) ^ GF128_R : s.v >> 1;
    return r;
  endfunction
endpackage

// File: rtl/gcm_ghash_tag_if.sv
// gcm_ghash_tag_if: beat input and tag output handshakes of the GHASH/tag unit
interface gcm_ghash_tag_if;
  import gcm_pkg::*;
  logic i_valid, o_ready, o_tag_valid, i_tag_ready, o_err;
  logic [2:0] i_phase;
  block_t i_h, i_encrypted_j0, i_aad, i_cipher_text, i_instance_size, o_tag;
  modport master (
    output i_valid, i_phase, i_h, i_encrypted_j0, i_aad, i_cipher_text, i_instance_size, i_tag_ready,
    input o_ready, o_tag, o_tag_valid, o_err
  );
  modport slave (
    input i_valid, i_phase, i_h, i_encrypted_j0, i_aad, i_cipher_text, i_instance_size, i_tag_ready,
    output o_ready, o_tag, o_tag_valid, o_err
  );
endinterface

// File: rtl/gcm_ghash_tag_mul.sv
// gf128_mul_digit: combinational DIGIT-bit slice of the serial GF(2^128) multiplier
module gf128_mul_digit
  import gcm_pkg::*;
#(
  parameter int DIGIT = 8
) (
  input  block_t           z,
  input  block_t           v,
  input  logic [0:DIGIT-1] x,
  output block_t           zo,
  output block_t           vo
);
  gf_t s;
  always_comb begin
    s.z = z;
    s.v = v;
    for (int i = 0; i < DIGIT; i++) s = gf128_step(s, x[i]);
    zo = s.z;
    vo = s.v;
  end
endmodule

// File: rtl/gcm_ghash_tag.sv
// gcm_ghash_tag: digit-serial GHASH over AAD/ciphertext/length beats, emits T = GHASH ^ E(J0)
module gcm_ghash_tag
  import gcm_pkg::*;
#(
  parameter int DIGIT = 8
) (
  input logic            clk,
  input logic            rst_n,
  gcm_ghash_tag_if.slave bus
);
  localparam int STEPS = 128 / DIGIT;
  localparam int CW = $clog2(STEPS);
  state_t state, state_n;
  block_t y, h, ej0, z, v, x, zo, vo, blk, tag;
  logic [CW-1:0] cnt;
  logic is_len, seen_data, err, tag_valid, ready, accept, legal, last;
  gf128_mul_digit #(.DIGIT(DIGIT)) u_mul (.z(z), .v(v), .x(x[0:DIGIT-1]), .zo(zo), .vo(vo));
  always_comb begin
    ready = state == S_IDLE || state == S_ACC;
    accept = bus.i_valid && ready;
    legal = bus.i_phase == PH_DATA || bus.i_phase == PH_LEN ||
            (bus.i_phase == PH_AAD && !(state == S_ACC && seen_data));
    last = cnt == CW'(STEPS - 1);
    blk = bus.i_phase == PH_AAD ? bus.i_aad : bus.i_phase == PH_DATA ? bus.i_cipher_text : bus.i_instance_size;
    state_n = accept && legal ? S_MUL :
              state == S_MUL && last ? (is_len ? S_TAG : S_ACC) :
              state == S_TAG && bus.i_tag_ready ? S_IDLE : state;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else state <= state_n;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {y, h, ej0, z, v, x, tag} <= '0;
      cnt <= '0;
      {is_len, seen_data, err, tag_valid} <= '0;
    end else begin
      err <= accept && !legal;
      if (accept && legal) begin
        if (state == S_IDLE) begin
          h <= bus.i_h;
          ej0 <= bus.i_encrypted_j0;
        end
        // A new message starts from Y=0 and uses the subkey arriving with its first beat
        z <= '0;
        v <= state == S_IDLE ? bus.i_h : h;
        x <= (state == S_IDLE ? '0 : y) ^ blk;
        cnt <= '0;
        is_len <= bus.i_phase == PH_LEN;
        seen_data <= bus.i_phase == PH_DATA || (state == S_ACC && seen_data);
      end else if (state == S_MUL) begin
        z <= zo;
        v <= vo;
        x <= x << DIGIT;
        cnt <= cnt + CW'(1);
        if (last) begin
          y <= zo;
          if (is_len) begin
            tag <= zo ^ ej0;
            tag_valid <= 1'b1;
          end
        end
      end else if (state == S_TAG && bus.i_tag_ready) begin
        tag_valid <= 1'b0;
        y <= '0;
      end
    end
  end
  assign bus.o_ready = ready;
  assign bus.o_tag = tag;
  assign bus.o_tag_valid = tag_valid;
  assign bus.o_err = err;
endmodule
